mem_stage: RTL and testbench

Memory-access stage of the 16-bit pipeline, directly downstream of the execute stage. It consumes the registered ALU result (used as the address) and the forwarded B operand (used as store data). It performs loads and stores over a variable-latency request/acknowledge data-memory port, stalling upstream while an access is outstanding, and produces registered write-back data for the write-back stage.

---
 rtl/mem_stage_pkg.sv | 35 +++
 rtl/mem_timeout_counter.sv | 35 +++
 rtl/mem_stage.sv | 122 ++++++++++++
 tb/tb_mem_stage.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_stage_pkg.sv
// Shared types and defaults for the pipeline memory-access stage.
// Provides the FSM state encoding and the decode of the {MemRead, MemWrite} control pair.
package mem_stage_pkg;

  localparam int DATA_W_DEFAULT  = 16;
  localparam int TIMEOUT_DEFAULT = 15;

  // Bit positions inside the 2-bit control field {MemRead, MemWrite}.
  localparam int SIG_MEMREAD  = 1;
  localparam int SIG_MEMWRITE = 0;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_t;

  typedef enum logic [1:0] {
    OP_ALU,
    OP_LOAD,
    OP_STORE,
    OP_ILLEGAL
  } mem_op_t;

  function automatic mem_op_t decode_op(input logic [1:0] sig);
    mem_op_t op;
    unique case ({sig[SIG_MEMREAD], sig[SIG_MEMWRITE]})
      2'b00:   op = OP_ALU;
      2'b10:   op = OP_LOAD;
      2'b01:   op = OP_STORE;
      default: op = OP_ILLEGAL;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/mem_timeout_counter.sv
// Saturating wait-cycle counter for an outstanding memory request.
// expired is combinational: it marks the un-acknowledged cycle that brings the count to TIMEOUT.
module mem_timeout_counter
  import mem_stage_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic clk,
  input  logic reset,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expired
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] r_count;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values; the reset branch is inside the clocked block (synchronous).
  always_ff @(posedge clk) begin
    if (reset) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_enable && (r_count != CNT_MAX)) begin
      r_count <= r_count + CNT_W'(1);
    end
  end

  assign o_expired = i_enable && (r_count >= CNT_LAST);

endmodule

// File: rtl/mem_stage.sv
// Memory-access pipeline stage: loads/stores over a request/acknowledge port with
// timeout, upstream stall generation and a registered write-back output.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEFAULT,
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] alu_result,
  input  logic [DATA_W-1:0] store_data,
  input  logic [1:0]        signals,
  output logic              stall,
  output logic              mem_req,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic              wb_valid,
  output logic [DATA_W-1:0] wb_data,
  output logic              mem_err
);

  state_t            r_state;
  logic              r_mem_req;
  logic              r_mem_we;
  logic [DATA_W-1:0] r_mem_addr;
  logic [DATA_W-1:0] r_mem_wdata;
  logic              r_wb_valid;
  logic [DATA_W-1:0] r_wb_data;
  logic              r_mem_err;

  mem_op_t w_op;
  logic    w_in_wait;
  logic    w_is_mem_op;
  logic    w_cnt_clear;
  logic    w_cnt_enable;
  logic    w_expired;

  assign w_op         = decode_op(signals);
  assign w_in_wait    = (r_state == WAIT);
  assign w_is_mem_op  = (w_op == OP_LOAD) || (w_op == OP_STORE);
  assign w_cnt_clear  = !w_in_wait;
  assign w_cnt_enable = w_in_wait && !mem_ack;

  mem_timeout_counter #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .clk       (clk),
    .reset     (reset),
    .i_clear   (w_cnt_clear),
    .i_enable  (w_cnt_enable),
    .o_expired (w_expired)
  );

  // The final timeout cycle releases upstream, matching the cycle in which an ack would.
  assign stall = (w_in_wait && !mem_ack && !w_expired)
              || (!w_in_wait && in_valid && w_is_mem_op);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= IDLE;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_wb_valid  <= 1'b0;
      r_wb_data   <= '0;
      r_mem_err   <= 1'b0;
    end else begin
      r_wb_valid <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (in_valid) begin
            unique case (w_op)
              OP_ALU: begin
                r_wb_data  <= alu_result;
                r_wb_valid <= 1'b1;
              end
              OP_LOAD, OP_STORE: begin
                r_mem_req   <= 1'b1;
                r_mem_we    <= (w_op == OP_STORE);
                r_mem_addr  <= alu_result;
                r_mem_wdata <= store_data;
                r_state     <= WAIT;
              end
              default: r_mem_err <= 1'b1;
            endcase
          end
        end
        WAIT: begin
          // Ack takes priority over a timeout landing in the same cycle.
          if (mem_ack) begin
            r_mem_req <= 1'b0;
            r_state   <= IDLE;
            if (!r_mem_we) begin
              r_wb_data  <= mem_rdata;
              r_wb_valid <= 1'b1;
            end
          end else if (w_expired) begin
            r_mem_req <= 1'b0;
            r_mem_err <= 1'b1;
            r_state   <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign mem_req   = r_mem_req;
  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign wb_valid  = r_wb_valid;
  assign wb_data   = r_wb_data;
  assign mem_err   = r_mem_err;

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed scenarios followed by a random
// instruction stream scored against a transaction-level model with its own memory.
module tb_mem_stage;

  localparam int DW  = 16;
  localparam int TMO = 15;

  localparam int K_ALU = 0;
  localparam int K_LD  = 1;
  localparam int K_ST  = 2;
  localparam int K_ILL = 3;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          in_valid = 1'b0;
  logic [DW-1:0] alu_result = '0;
  logic [DW-1:0] store_data = '0;
  logic [1:0]    signals = 2'b00;
  logic          stall;
  logic          mem_req;
  logic          mem_we;
  logic [DW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata = '0;
  logic          mem_ack = 1'b0;
  logic          wb_valid;
  logic [DW-1:0] wb_data;
  logic          mem_err;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  logic [DW-1:0] mem_model [int];
  logic [DW-1:0] exp_wb  = '0;
  logic          exp_err = 1'b0;

  mem_stage #(.DATA_W(DW), .TIMEOUT(TMO)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .alu_result (alu_result),
    .store_data (store_data),
    .signals    (signals),
    .stall      (stall),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .mem_ack    (mem_ack),
    .wb_valid   (wb_valid),
    .wb_data    (wb_data),
    .mem_err    (mem_err)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: observed no end of test, expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] mem_read(input logic [DW-1:0] addr);
    if (mem_model.exists(int'(addr))) return mem_model[int'(addr)];
    return addr ^ 16'h5A5A;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_req"},  mem_req, 0);
    check({tag, "_wbv"},  wb_valid, 0);
    check({tag, "_wbd"},  wb_data, exp_wb);
    check({tag, "_err"},  mem_err, exp_err);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    in_valid = 1'b0;
    signals = 2'b00;
    mem_ack = 1'b0;
    step();
    reset = 1'b0;
    exp_wb  = '0;
    exp_err = 1'b0;
    check("rst_req",   mem_req, 0);
    check("rst_we",    mem_we, 0);
    check("rst_addr",  mem_addr, 0);
    check("rst_wdata", mem_wdata, 0);
    check("rst_wbv",   wb_valid, 0);
    check("rst_wbd",   wb_data, 0);
    check("rst_err",   mem_err, 0);
    check("rst_stall", stall, 0);
  endtask

  task automatic idle_cycle(input logic spurious_ack);
    in_valid  = 1'b0;
    mem_ack   = spurious_ack;
    mem_rdata = 16'hDEAD;
    #1;
    check("idle_stall", stall, 0);
    step();
    mem_ack = 1'b0;
    check_idle_outputs("idle");
  endtask

  // One instruction from presentation to completion; lat = cycle of ack (0 = never).
  task automatic issue(input int kind, input logic [DW-1:0] addr,
                       input logic [DW-1:0] data, input int lat);
    int  k;
    bit  done;
    bit  acked;
    in_valid   = 1'b1;
    alu_result = addr;
    store_data = data;
    mem_ack    = 1'b0;
    case (kind)
      K_ALU:   signals = 2'b00;
      K_LD:    signals = 2'b10;
      K_ST:    signals = 2'b01;
      default: signals = 2'b11;
    endcase
    #1;
    check("accept_stall", stall, (kind == K_LD || kind == K_ST));
    step();
    if (kind == K_ALU) begin
      exp_wb = addr;
      check("alu_wbv", wb_valid, 1);
      check("alu_wbd", wb_data, exp_wb);
      check("alu_req", mem_req, 0);
    end else if (kind == K_ILL) begin
      exp_err = 1'b1;
      check("ill_err", mem_err, 1);
      check("ill_wbv", wb_valid, 0);
      check("ill_req", mem_req, 0);
    end else begin
      k = 1;
      done = 1'b0;
      acked = 1'b0;
      while (!done) begin
        check("wait_req",   mem_req, 1);
        check("wait_addr",  mem_addr, addr);
        check("wait_we",    mem_we, (kind == K_ST));
        check("wait_wdata", mem_wdata, data);
        if (k == lat) begin
          mem_ack   = 1'b1;
          mem_rdata = (kind == K_LD) ? mem_read(addr) : 16'($urandom);
          acked     = 1'b1;
        end else begin
          mem_ack   = 1'b0;
          mem_rdata = 16'($urandom);
        end
        #1;
        check("wait_stall", stall, (k != lat && k != TMO));
        step();
        mem_ack    = 1'b0;
        in_valid   = 1'($urandom);
        alu_result = 16'($urandom);
        store_data = 16'($urandom);
        signals    = 2'($urandom);
        done = acked || (k == TMO);
        k++;
      end
      check("done_req", mem_req, 0);
      if (acked) begin
        if (kind == K_LD) exp_wb = mem_read(addr);
        else mem_model[int'(addr)] = data;
        check("done_wbv", wb_valid, (kind == K_LD));
      end else begin
        exp_err = 1'b1;
        check("tmo_wbv", wb_valid, 0);
      end
    end
    check("end_err", mem_err, exp_err);
    check("end_wbd", wb_data, exp_wb);
    in_valid = 1'b0;
    signals  = 2'b00;
  endtask

  initial begin
    int kind;
    int lat;
    logic [DW-1:0] addr;

    step();
    do_reset();

    // Pass-through, 3-cycle load, single-cycle store then back-to-back ALU op.
    issue(K_ALU, 16'h0005, 16'h0000, 0);
    mem_model[16'h0010] = 16'hBEEF;
    issue(K_LD,  16'h0010, 16'h0000, 3);
    issue(K_ST,  16'h0020, 16'hFFF6, 1);
    issue(K_ALU, 16'h1234, 16'h0000, 0);
    issue(K_LD,  16'h0020, 16'h0000, 2);
    idle_cycle(1'b0);

    // Timeout, then sticky error across later traffic.
    issue(K_LD,  16'h0030, 16'h0000, 0);
    issue(K_ALU, 16'h0042, 16'h0000, 0);
    idle_cycle(1'b0);

    // Ack on the final allowed cycle wins over the timeout.
    do_reset();
    mem_model[16'h0040] = 16'hCAFE;
    issue(K_LD, 16'h0040, 16'h0000, TMO);

    issue(K_ILL, 16'h0050, 16'h1111, 0);
    idle_cycle(1'b0);

    // Reset during an outstanding load, then spurious ack in IDLE.
    do_reset();
    in_valid   = 1'b1;
    alu_result = 16'h0060;
    signals    = 2'b10;
    step();
    in_valid = 1'b0;
    signals  = 2'b00;
    check("mid_req", mem_req, 1);
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("abort_req",  mem_req, 0);
    check("abort_addr", mem_addr, 0);
    check("abort_wbv",  wb_valid, 0);
    check("abort_wbd",  wb_data, 0);
    check("abort_err",  mem_err, 0);
    mem_ack = 1'b1;
    #1;
    check("abort_stall", stall, 0);
    step();
    mem_ack = 1'b0;
    check_idle_outputs("spur");
    idle_cycle(1'b1);
    issue(K_ALU, 16'h0077, 16'h0000, 0);

    // Random instruction stream over a small address pool.
    do_reset();
    for (int n = 0; n < 80; n++) begin
      case ($urandom_range(0, 19))
        0:                kind = K_ILL;
        1, 2, 3, 4, 5, 6: kind = K_ALU;
        7, 8, 9, 10, 11:  kind = K_ST;
        default:          kind = K_LD;
      endcase
      case ($urandom_range(0, 11))
        0:       lat = 0;
        1:       lat = TMO;
        default: lat = $urandom_range(1, 5);
      endcase
      addr = (kind == K_ALU) ? 16'($urandom) : 16'($urandom_range(0, 7) * 4);
      issue(kind, addr, 16'($urandom), lat);
      if ($urandom_range(0, 3) == 0) idle_cycle(1'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
